tdm_scan_ctrl: RTL and testbench
================================

Name: tdm_scan_ctrl

Overview:
- Time-division scan controller sitting directly upstream and downstream of the team's gate-level 4:1 mux (MUX4).
- Drives the mux select lines s0/s1, waits a programmable settle time per channel, and samples the mux output f.
- Assembles the four samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake.
- Mux wiring is fixed: channel index n = {s1,s0} selects input i<n>.

Parameters:
- SETTLE_CYCLES, 1, cycles the select is held before sampling; legal range 0..15.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; scanning is enabled while high.
- mux_f  in  1  output f of MUX4.
- sel_s0  out  1  to MUX4 s0; equals channel index bit 0.
- sel_s1  out  1  to MUX4 s1; equals channel index bit 1.
- frame_data  out  4  bit n holds the sample of channel n.
- frame_valid  out  1  frame available.
- frame_ready  in  1  downstream accepts the frame.
- busy  out  1  high whenever the state is not IDLE.
- frame_cnt  out  CNT_W  count of accepted frames; wraps modulo 2^CNT_W.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - On reset: state=IDLE, ch=0, settle cnt=0, sel_s0=0, sel_s1=0, frame_data=0, frame_valid=0, busy=0, frame_cnt=0.
  - Reset asserted mid-scan or mid-handshake aborts immediately. No partial frame is ever emitted.
- Outputs: all are registered; no combinational path from inputs to outputs.
- IDLE:
  - Selects held at 0.
  - run=1 sampled -> SETTLE next cycle, with ch=0 and cnt=0.
- SETTLE:
  - sel = ch. cnt increments every cycle.
  - When cnt==SETTLE_CYCLES: capture mux_f into shadow bit ch.
    - If ch<3: ch++, cnt=0, and the select changes on the next cycle.
    - If ch==3: go to OUTPUT. frame_data is loaded with the full 4-bit shadow, including this cycle's sample. frame_valid=1.
  - Each channel occupies SETTLE_CYCLES+1 cycles.
  - SETTLE_CYCLES=0 samples each channel in the cycle its select is driven. The bench mux is combinational, so this is legal.
- OUTPUT:
  - frame_valid held high and frame_data held stable until frame_ready=1. Backpressure is indefinite and mux_f is ignored.
  - Selects hold at 3.
  - Handshake (frame_valid & frame_ready) at the clock edge: frame_valid -> 0, frame_cnt++ (wrap).
    - If run=1: -> SETTLE with ch=0, cnt=0.
    - Else: -> IDLE with selects -> 0.
- Latency: from the cycle run is first sampled high in IDLE to frame_valid high is 1 + 4*(SETTLE_CYCLES+1) cycles. With the default this is 9.
- Continuous run: the gap between frames is at least 4*(SETTLE_CYCLES+1) cycles of frame_valid=0.
- run deasserted mid-scan: the current frame completes and is offered normally. The block then returns to IDLE after the handshake.
- frame_ready while frame_valid=0: ignored, no effect.
- frame_cnt wrap: 2^CNT_W-1 -> 0 on the next accepted frame. No flag is raised.

Decomposition:
- Package tdm_scan_pkg holds:
  - state enum {IDLE, SETTLE, OUTPUT};
  - localparams NUM_CH=4 and CH_W=2;
  - SETTLE_W=4.
- One sub-module is natural: settle_timer. It is a loadable up-counter with clear and a done flag (cnt==limit), instantiated once.
- MUX4 is instantiated beside tdm_scan_ctrl at the parent level, not inside it.

Test Plan:
- Default params; mux inputs i0..i3=1,0,1,1 via a MUX4 instance; run=1 at cycle 0; frame_ready=1 -> frame_valid rises at cycle 9 with frame_data=4'b1101; frame_cnt=1 after the handshake.
- Stall: frame_ready=0 for 20 cycles, inputs toggled meanwhile -> frame_data stays 4'b1101, valid stays high, selects stay 2'b11; ready=1 -> exactly one accept, frame_cnt+1.
- SETTLE_CYCLES=0 with inputs 0,1,1,0 -> selects step 0,1,2,3 on consecutive cycles; frame_valid at cycle 5; frame_data=4'b0110.
- run dropped at channel 1 of the first frame -> frame still completes with the correct value; IDLE and busy=0 the cycle after the handshake; selects=0.
- rst_n pulsed low mid-SETTLE (ch=2), asynchronously and not clock-aligned -> all outputs 0 immediately; after release with run=1, the first frame is a fresh full scan at full latency.
- CNT_W=2 forced; 5 frames accepted back-to-back with run held high -> frame_cnt sequence 1,2,3,0,1; inter-frame valid-low gap ≥ 8 cycles.

Source files
------------

// File: rtl/tdm_scan_pkg.sv
// Shared state encoding and sizing for the TDM scan controller and its settle timer.
package tdm_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUTPUT
  } state_e;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/tdm_scan_ctrl_settle_timer.sv
// Per-channel settle counter: counts up while enabled, clears on request,
// and flags done when the count equals the programmed limit.
module tdm_scan_ctrl_settle_timer
  import tdm_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [SETTLE_W-1:0] i_limit,
  output logic                o_done
);

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/tdm_scan_ctrl.sv
// Time-division scan controller: steps an external 4:1 mux through its channels,
// samples each after a settle time and offers the 4-bit frame over valid/ready.
module tdm_scan_ctrl
  import tdm_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             mux_f,
  output logic             sel_s0,
  output logic             sel_s1,
  output logic [3:0]       frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [SETTLE_W-1:0] LIMIT   = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);

  state_e              r_state;
  logic [CH_W-1:0]     r_ch;
  logic [NUM_CH-1:0]   r_shadow;
  logic [NUM_CH-1:0]   r_frame_data;
  logic                r_frame_valid;
  logic                r_busy;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [NUM_CH-1:0]   w_shadow_next;
  logic                w_done;
  logic                w_in_settle;
  logic                w_accept;

  assign w_in_settle = (r_state == SETTLE);
  assign w_accept    = r_frame_valid & frame_ready;

  // Timer is held at zero outside SETTLE so every channel starts from a fresh count.
  tdm_scan_ctrl_settle_timer u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (!w_in_settle || w_done),
    .i_en    (w_in_settle),
    .i_limit (LIMIT),
    .o_done  (w_done)
  );

  // Shadow including the current sample, so the last channel lands in the frame directly.
  always_comb begin
    w_shadow_next       = r_shadow;
    w_shadow_next[r_ch] = mux_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      r_shadow      <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= SETTLE;
            r_ch    <= '0;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (w_done) begin
            r_shadow <= w_shadow_next;
            if (r_ch == LAST_CH) begin
              r_state       <= OUTPUT;
              r_frame_data  <= w_shadow_next;
              r_frame_valid <= 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (w_accept) begin
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= r_frame_cnt + 1'b1;
            r_ch          <= '0;
            if (run) begin
              r_state <= SETTLE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_ch          <= '0;
          r_frame_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign sel_s0      = r_ch[0];
  assign sel_s1      = r_ch[1];
  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign busy        = r_busy;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// Bench for tdm_scan_ctrl: three instances (default, zero settle, 2-bit counter),
// each driving a behavioural 4:1 mux, with a queue of expected frames.
module tb_tdm_scan_ctrl;

  logic clk;
  logic rst_n;
  logic [2:0]      run;
  logic [2:0]      rdy;
  logic [2:0][3:0] mi;
  logic [2:0]      mf;
  logic [2:0]      s0;
  logic [2:0]      s1;
  logic [2:0][3:0] fd;
  logic [2:0]      fv;
  logic [2:0]      busy;
  logic [7:0]      fc_a;
  logic [7:0]      fc_b;
  logic [1:0]      fc_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         k;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MUX4 beside each controller: f = i{s1,s0}
  assign mf[0] = mi[0][{s1[0], s0[0]}];
  assign mf[1] = mi[1][{s1[1], s0[1]}];
  assign mf[2] = mi[2][{s1[2], s0[2]}];

  tdm_scan_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .run(run[0]), .mux_f(mf[0]),
    .sel_s0(s0[0]), .sel_s1(s1[0]), .frame_data(fd[0]), .frame_valid(fv[0]),
    .frame_ready(rdy[0]), .busy(busy[0]), .frame_cnt(fc_a)
  );

  tdm_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run(run[1]), .mux_f(mf[1]),
    .sel_s0(s0[1]), .sel_s1(s1[1]), .frame_data(fd[1]), .frame_valid(fv[1]),
    .frame_ready(rdy[1]), .busy(busy[1]), .frame_cnt(fc_b)
  );

  tdm_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .run(run[2]), .mux_f(mf[2]),
    .sel_s0(s0[2]), .sel_s1(s1[2]), .frame_data(fd[2]), .frame_valid(fv[2]),
    .frame_ready(rdy[2]), .busy(busy[2]), .frame_cnt(fc_c)
  );

  function automatic logic [7:0] cnt_of(input int k);
    case (k)
      0:       return fc_a;
      1:       return fc_b;
      default: return {6'd0, fc_c};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame: bit n is whatever the mux presents on input n.
  task automatic push_exp(input int k);
    exp_t e;
    e.k = k;
    for (int n = 0; n < 4; n++) e.data[n] = mi[k][n];
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int k, input int start, output int n);
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (!fv[k] && n < 100);
    if (!fv[k]) check($sformatf("timeout_valid_%0d", k), 32'(fv[k]), 1);
  endtask

  task automatic pop_check(input int k, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_inst"}, k, e.k);
    check({tag, "_data"}, 32'(fd[k]), 32'(e.data));
    check({tag, "_sel"}, {30'd0, s1[k], s0[k]}, 3);
    check({tag, "_busy"}, 32'(busy[k]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    run   = '0;
    rdy   = '0;
    mi    = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_%0d", k),
            {16'd0, fv[k], busy[k], s1[k], s0[k], fd[k], cnt_of(k)}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, ready held high throughout (ready while invalid is ignored)
    mi[0]  = 4'b1101;
    rdy[0] = 1'b1;
    push_exp(0);
    run[0] = 1'b1;
    wait_valid(0, 0, n);
    check("t1_latency", n, 9);
    check("t1_cnt_before", 32'(fc_a), 0);
    pop_check(0, "t1");
    run[0] = 1'b0;
    @(negedge clk);
    check("t1_cnt_after", 32'(fc_a), 1);
    check("t1_idle", {30'd0, fv[0], busy[0]}, 0);
    rdy[0] = 1'b0;

    // Indefinite backpressure with mux inputs changing underneath
    push_exp(0);
    run[0] = 1'b1;
    wait_valid(0, 0, n);
    check("t2_latency", n, 9);
    pop_check(0, "t2");
    run[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mi[0] = 4'($urandom);
      @(negedge clk);
      check("t2_stall", {25'd0, fv[0], s1[0], s0[0], fd[0]}, {25'd0, 1'b1, 2'b11, 4'b1101});
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("t2_accept_valid", 32'(fv[0]), 0);
    check("t2_cnt", 32'(fc_a), 2);
    repeat (3) @(negedge clk);
    check("t2_one_accept", 32'(fc_a), 2);
    check("t2_busy", 32'(busy[0]), 0);

    // run dropped while channel 1 is being settled
    mi[0] = 4'b1010;
    push_exp(0);
    run[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_mid_sel", {30'd0, s1[0], s0[0]}, 1);
    check("t3_mid_busy", 32'(busy[0]), 1);
    run[0] = 1'b0;
    wait_valid(0, 3, n);
    check("t3_latency", n, 9);
    pop_check(0, "t3");
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("t3_after", {23'd0, fv[0], busy[0], s1[0], s0[0], fc_a}, {23'd0, 4'b0000, 8'd3});

    // Asynchronous reset while channel 2 is settling
    mi[0] = 4'b1101;
    push_exp(0);
    run[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_pre_sel", {30'd0, s1[0], s0[0]}, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_out", {16'd0, fv[0], busy[0], s1[0], s0[0], fd[0], fc_a}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("t4_rst_hold", {16'd0, fv[0], busy[0], s1[0], s0[0], fd[0], fc_a}, 0);
    #2 rst_n = 1'b1;
    push_exp(0);
    wait_valid(0, 0, n);
    check("t4_latency", n, 9);
    pop_check(0, "t4");
    run[0] = 1'b0;
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check("t4_cnt", 32'(fc_a), 1);

    // Zero settle time: one cycle per channel
    mi[1]  = 4'b0110;
    rdy[1] = 1'b1;
    push_exp(1);
    run[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t5_sel_%0d", i), {29'd0, fv[1], s1[1], s0[1]}, i);
    end
    wait_valid(1, 4, n);
    check("t5_latency", n, 5);
    pop_check(1, "t5");
    run[1] = 1'b0;
    @(negedge clk);
    check("t5_cnt", 32'(fc_b), 1);
    check("t5_busy", 32'(busy[1]), 0);

    // 2-bit counter wrap over five back-to-back frames
    mi[2]  = 4'($urandom);
    rdy[2] = 1'b1;
    push_exp(2);
    run[2] = 1'b1;
    wait_valid(2, 0, n);
    check("t6_latency", n, 9);
    for (int f = 0; f < 5; f++) begin
      pop_check(2, $sformatf("t6_f%0d", f));
      if (f == 4) begin
        run[2] = 1'b0;
      end else begin
        mi[2] = 4'($urandom);
        push_exp(2);
      end
      @(negedge clk);
      check($sformatf("t6_cnt_%0d", f), 32'(fc_c), (f + 1) % 4);
      check($sformatf("t6_low_%0d", f), 32'(fv[2]), 0);
      if (f < 4) begin
        wait_valid(2, 1, n);
        check($sformatf("t6_gap_%0d", f), 32'(n - 1 >= 8), 1);
      end
    end
    check("t6_busy_end", 32'(busy[2]), 0);
    check("t6_sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
